// File: rtl/ctrl_pkg.sv
// Shared control-bus definitions: arbiter state encoding, command word width
// and the requester IDs that the accelerator sequencing FSMs use on the bus.
package ctrl_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        GRANTED = 1'b1
    } arb_state_t;

    localparam int CTRL_ADDRW = 24;
    localparam int CTRL_DATAW = CTRL_ADDRW + 8;

    // Requester slots on the control bus; index equals the arbiter req bit.
    localparam int MEM_ID = 0;
    localparam int SHA_ID = 1;
    localparam int AES_ID = 2;
    localparam int AUX_ID = 3;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first eligible requester searching upward
// from last_owner+1, wrapping around to last_owner itself.
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDW     = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] mask,
    input  logic [IDW-1:0]     last_owner,
    output logic [NUM_REQ-1:0] onehot,
    output logic [IDW-1:0]     idx,
    output logic               any
);

    logic [NUM_REQ-1:0] eligible;

    assign eligible = req & ~mask;

    // Pass 0 covers indices above last_owner, pass 1 wraps to the bottom.
    always_comb begin
        onehot = '0;
        idx    = '0;
        any    = 1'b0;
        for (int pass = 0; pass < 2; pass++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!any && eligible[i] && (pass == 1 || IDW'(i) > last_owner)) begin
                    any       = 1'b1;
                    onehot[i] = 1'b1;
                    idx       = IDW'(i);
                end
            end
        end
    end

endmodule

// File: rtl/ctrl_bus_arbiter.sv
// Round-robin arbiter and registered command mux for the shared control bus.
// Define CTRL_ARB_TIMEOUT_EN to enable the hold-timeout watchdog and masking.
module ctrl_bus_arbiter
    import ctrl_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int DATAW    = CTRL_DATAW,
    parameter int HOLD_MAX = 255
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req,
    output logic [NUM_REQ-1:0]         grant,
    input  logic [NUM_REQ*DATAW-1:0]   data_in,
    input  logic [NUM_REQ-1:0]         valid_in,
    output logic [DATAW-1:0]           bus_data,
    output logic                       bus_valid,
    output logic [$clog2(NUM_REQ)-1:0] owner_id,
    output logic                       busy,
    output logic                       timeout
);

    localparam int IDW = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 8 || HOLD_MAX < 2 || HOLD_MAX > 65535) begin : g_param_check
        $error("ctrl_bus_arbiter: parameter out of range");
    end

    arb_state_t         state;
    logic [IDW-1:0]     last_owner;
    logic [NUM_REQ-1:0] mask;
    logic [NUM_REQ-1:0] pick_req;
    logic [NUM_REQ-1:0] pick_onehot;
    logic [IDW-1:0]     pick_idx;
    logic               pick_any;
    logic               owner_req;
    logic               owner_valid;
    logic               hold_hit;
    logic               rearb;
    logic [DATAW-1:0]   words [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_words
        assign words[i] = data_in[i*DATAW +: DATAW];
    end

    assign owner_req   = req[owner_id];
    assign owner_valid = valid_in[owner_id];

    // The current owner never competes on its own handover edge; this also
    // keeps a timed-out owner from winning the slot it just lost.
    assign pick_req = req & ~grant;

`ifdef CTRL_ARB_TIMEOUT_EN
    localparam logic [15:0] HOLD_LAST = 16'(HOLD_MAX - 1);

    logic [15:0] hold_cnt;

    assign hold_hit = (state == GRANTED) && owner_req && (hold_cnt == HOLD_LAST);

    // A revoked owner stays excluded until it lets go of its request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask <= '0;
        end else begin
            mask <= (mask & req) | (hold_hit ? grant : '0);
        end
    end
`else
    assign hold_hit = 1'b0;
    assign mask     = '0;
    assign timeout  = 1'b0;
`endif

    always_comb begin
        rearb = 1'b1;
        if (state == GRANTED) begin
            rearb = !owner_req || hold_hit;
        end
    end

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDW     (IDW)
    ) u_pick (
        .req        (pick_req),
        .mask       (mask),
        .last_owner (last_owner),
        .onehot     (pick_onehot),
        .idx        (pick_idx),
        .any        (pick_any)
    );

    // Grant FSM plus the one-stage bus register; a handover happens on the
    // same edge the owner lets go, so busy never drops between owners.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            grant      <= '0;
            owner_id   <= '0;
            busy       <= 1'b0;
            last_owner <= IDW'(NUM_REQ - 1);
            bus_data   <= '0;
            bus_valid  <= 1'b0;
`ifdef CTRL_ARB_TIMEOUT_EN
            hold_cnt   <= '0;
            timeout    <= 1'b0;
`endif
        end else begin
            bus_valid <= busy & owner_valid;
            bus_data  <= (busy & owner_valid) ? words[owner_id] : '0;
`ifdef CTRL_ARB_TIMEOUT_EN
            timeout   <= hold_hit;
            if (state == GRANTED) begin
                hold_cnt <= hold_cnt + 16'd1;
            end
`endif
            if (rearb) begin
                if (pick_any) begin
                    state      <= GRANTED;
                    grant      <= pick_onehot;
                    owner_id   <= pick_idx;
                    last_owner <= pick_idx;
                    busy       <= 1'b1;
`ifdef CTRL_ARB_TIMEOUT_EN
                    hold_cnt   <= '0;
`endif
                end else begin
                    state <= IDLE;
                    grant <= '0;
                    busy  <= 1'b0;
                end
            end
        end
    end

endmodule
